// File: rtl/router_sync.sv
// Router address latch, FIFO write/full steering and per-port read timeout.
// A port left valid but unread for 30 edges gets a one-cycle soft reset.
module router_sync (
    input  logic       clock,
    input  logic       resetn,
    input  logic       detect_add,
    input  logic [1:0] data_in,
    input  logic       write_enb_reg,
    input  logic       read_enb_0,
    input  logic       read_enb_1,
    input  logic       read_enb_2,
    input  logic       empty_0,
    input  logic       empty_1,
    input  logic       empty_2,
    input  logic       full_0,
    input  logic       full_1,
    input  logic       full_2,
    output logic [2:0] write_enb,
    output logic       fifo_full,
    output logic       vld_out_0,
    output logic       vld_out_1,
    output logic       vld_out_2,
    output logic       soft_reset_0,
    output logic       soft_reset_1,
    output logic       soft_reset_2
);

    localparam logic [4:0] LAST = 5'd29;

    logic [1:0]      addr_q, addr_d;
    logic [2:0][4:0] cnt_q, cnt_d;
    logic [2:0]      sr_q, sr_d;
    logic [2:0]      vld, rd, full;

    assign vld  = {~empty_2, ~empty_1, ~empty_0};
    assign rd   = {read_enb_2, read_enb_1, read_enb_0};
    assign full = {full_2, full_1, full_0};

    assign vld_out_0 = vld[0];
    assign vld_out_1 = vld[1];
    assign vld_out_2 = vld[2];

    assign soft_reset_0 = sr_q[0];
    assign soft_reset_1 = sr_q[1];
    assign soft_reset_2 = sr_q[2];

    always_comb begin
        addr_d = detect_add ? data_in : addr_q;
        cnt_d  = cnt_q;
        sr_d   = '0;
        for (int n = 0; n < 3; n++) begin
            if (vld[n] && !rd[n]) begin
                // 30th consecutive stall edge fires and restarts the window
                if (cnt_q[n] == LAST) begin
                    cnt_d[n] = '0;
                    sr_d[n]  = 1'b1;
                end else begin
                    cnt_d[n] = cnt_q[n] + 5'd1;
                end
            end else begin
                cnt_d[n] = '0;
            end
        end
    end

    always_comb begin
        write_enb = '0;
        fifo_full = 1'b0;
        case (addr_q)
            2'd0: begin
                write_enb[0] = write_enb_reg;
                fifo_full    = full[0];
            end
            2'd1: begin
                write_enb[1] = write_enb_reg;
                fifo_full    = full[1];
            end
            2'd2: begin
                write_enb[2] = write_enb_reg;
                fifo_full    = full[2];
            end
            default: begin
                write_enb = '0;
                fifo_full = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            addr_q <= 2'b11;
            cnt_q  <= '0;
            sr_q   <= '0;
        end else begin
            addr_q <= addr_d;
            cnt_q  <= cnt_d;
            sr_q   <= sr_d;
        end
    end

endmodule

// File: tb/tb_router_sync.sv
// Directed bench for router_sync: address steering, valid flags,
// timeout soft-reset pulses and asynchronous reset behaviour.
module tb_router_sync;

    logic       clock = 1'b0;
    logic       resetn;
    logic       detect_add;
    logic [1:0] data_in;
    logic       write_enb_reg;
    logic       read_enb_0, read_enb_1, read_enb_2;
    logic       empty_0, empty_1, empty_2;
    logic       full_0, full_1, full_2;
    logic [2:0] write_enb;
    logic       fifo_full;
    logic       vld_out_0, vld_out_1, vld_out_2;
    logic       soft_reset_0, soft_reset_1, soft_reset_2;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clock = ~clock;

    router_sync dut (
        .clock        (clock),
        .resetn       (resetn),
        .detect_add   (detect_add),
        .data_in      (data_in),
        .write_enb_reg(write_enb_reg),
        .read_enb_0   (read_enb_0),
        .read_enb_1   (read_enb_1),
        .read_enb_2   (read_enb_2),
        .empty_0      (empty_0),
        .empty_1      (empty_1),
        .empty_2      (empty_2),
        .full_0       (full_0),
        .full_1       (full_1),
        .full_2       (full_2),
        .write_enb    (write_enb),
        .fifo_full    (fifo_full),
        .vld_out_0    (vld_out_0),
        .vld_out_1    (vld_out_1),
        .vld_out_2    (vld_out_2),
        .soft_reset_0 (soft_reset_0),
        .soft_reset_1 (soft_reset_1),
        .soft_reset_2 (soft_reset_2)
    );

    task automatic check(input string tag, input logic [7:0] obs,
                         input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic edge_n();
        @(posedge clock);
        @(negedge clock);
    endtask

    // n stall edges; soft_reset must be 0 except 'fire' after the last
    task automatic stall_window(input string tag, input int n,
                                input logic [2:0] fire);
        for (int i = 1; i <= n; i++) begin
            edge_n();
            check(tag, {5'b0, soft_reset_2, soft_reset_1, soft_reset_0},
                  (i == n) ? {5'b0, fire} : 8'h00);
        end
    endtask

    initial begin
        resetn        = 1'b0;
        detect_add    = 1'b0;
        data_in       = 2'b00;
        write_enb_reg = 1'b1;
        {read_enb_2, read_enb_1, read_enb_0} = 3'b000;
        {empty_2, empty_1, empty_0}          = 3'b111;
        {full_2, full_1, full_0}             = 3'b111;
        #12;
        check("rst_we", {5'b0, write_enb}, 8'h00);
        check("rst_full", {7'b0, fifo_full}, 8'h00);
        check("rst_sr", {5'b0, soft_reset_2, soft_reset_1, soft_reset_0}, 8'h00);
        check("rst_vld", {5'b0, vld_out_2, vld_out_1, vld_out_0}, 8'h00);
        @(negedge clock);
        resetn = 1'b1;
        {full_2, full_1, full_0} = 3'b000;

        // capture addr 1; same-cycle decode still uses addr 3
        detect_add = 1'b1;
        data_in    = 2'b01;
        #1 check("we_old", {5'b0, write_enb}, 8'h00);
        edge_n();
        detect_add = 1'b0;
        #1 check("we_p1", {5'b0, write_enb}, 8'h02);
        full_1 = 1'b1;
        #1 check("full_p1", {7'b0, fifo_full}, 8'h01);
        full_1 = 1'b0;
        full_0 = 1'b1;
        #1 check("full_p1_f0", {7'b0, fifo_full}, 8'h00);
        write_enb_reg = 1'b0;
        #1 check("we_off", {5'b0, write_enb}, 8'h00);
        write_enb_reg = 1'b1;

        // invalid address with every FIFO full
        {full_2, full_1, full_0} = 3'b111;
        detect_add = 1'b1;
        data_in    = 2'b11;
        edge_n();
        check("we_p3", {5'b0, write_enb}, 8'h00);
        check("full_p3", {7'b0, fifo_full}, 8'h00);
        data_in = 2'b10;
        edge_n();
        check("we_p2", {5'b0, write_enb}, 8'h04);
        {full_2, full_1, full_0} = 3'b011;
        #1 check("full_p2", {7'b0, fifo_full}, 8'h00);
        data_in = 2'b00;
        edge_n();
        detect_add = 1'b0;
        data_in    = 2'b11;
        check("we_p0", {5'b0, write_enb}, 8'h01);
        check("full_p0", {7'b0, fifo_full}, 8'h01);
        {full_2, full_1, full_0} = 3'b000;
        empty_1 = 1'b0;
        #1 check("vld_1", {5'b0, vld_out_2, vld_out_1, vld_out_0}, 8'h02);
        empty_1 = 1'b1;

        // port 2 timeout, then a second window
        empty_2 = 1'b0;
        stall_window("to2_a", 30, 3'b100);
        check("we_keep", {5'b0, write_enb}, 8'h01);
        stall_window("to2_b", 30, 3'b100);
        empty_2 = 1'b1;
        edge_n();
        check("to2_end", {5'b0, soft_reset_2, soft_reset_1, soft_reset_0}, 8'h00);

        // port 0 read at edge 20 restarts the window
        empty_0 = 1'b0;
        stall_window("to0_pre", 19, 3'b000);
        read_enb_0 = 1'b1;
        edge_n();
        read_enb_0 = 1'b0;
        check("to0_rd", {5'b0, soft_reset_2, soft_reset_1, soft_reset_0}, 8'h00);
        stall_window("to0_post", 30, 3'b001);
        empty_0 = 1'b1;
        edge_n();

        // simultaneous timeouts on ports 0 and 1
        {empty_1, empty_0} = 2'b00;
        stall_window("to01", 30, 3'b011);
        {empty_1, empty_0} = 2'b11;
        edge_n();

        // reset in the middle of a port 1 window
        empty_1 = 1'b0;
        stall_window("to1_pre", 15, 3'b000);
        resetn = 1'b0;
        #1;
        check("mid_rst_we", {5'b0, write_enb}, 8'h00);
        check("mid_rst_vld", {5'b0, vld_out_2, vld_out_1, vld_out_0}, 8'h02);
        edge_n();
        resetn = 1'b1;
        stall_window("to1_post", 30, 3'b010);
        check("we_after_rst", {5'b0, write_enb}, 8'h00);
        empty_1 = 1'b1;
        edge_n();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/router_sync.md
ROUTER_SYNC -- requirements
Module: router_sync

Interface
REQ-001 SHALL have one clock and an asynchronous, active-low reset, named as below.
REQ-002 clock  in  1  rising-edge system clock.
REQ-003 resetn  in  1  asynchronous active-low reset.
REQ-004 detect_add  in  1  from FSM: current data_in is the header address.
REQ-005 data_in  in  2  header address field; 0/1/2 select output port, 3 invalid.
REQ-006 write_enb_reg  in  1  from FSM: write current byte to selected FIFO.
REQ-007 read_enb_0, read_enb_1, read_enb_2  in  1 each  read strobe from the destination of each output port.
REQ-008 empty_0, empty_1, empty_2  in  1 each  FIFO empty flags.
REQ-009 full_0, full_1, full_2  in  1 each  FIFO full flags.
REQ-010 write_enb  out  3  one-hot FIFO write enable; bit n drives FIFO n.
REQ-011 fifo_full  out  1  full flag of the selected FIFO, to the FSM.
REQ-012 vld_out_0, vld_out_1, vld_out_2  out  1 each  data available at output port n.
REQ-013 soft_reset_0, soft_reset_1, soft_reset_2  out  1 each  registered one-cycle flush pulse to FIFO n and the FSM.

Function
REQ-014 SHALL hold a 2-bit address register, reset value 2'b11 (no port selected).
REQ-015 SHALL load data_in into the address register on every rising edge with detect_add=1; otherwise hold.
REQ-016 New address SHALL take effect the cycle after capture; same-cycle write_enb/fifo_full use the old value.
REQ-017 write_enb SHALL be combinational: write_enb_reg=1 and addr=n (n<3) -> bit n =1; all other cases 3'b000.
REQ-018 fifo_full SHALL be combinational: full_n when addr=n; 0 when addr=3.
REQ-019 vld_out_n SHALL equal ~empty_n, combinational, independent of address.
REQ-020 SHALL keep one 5-bit timeout counter per port, reset value 0.
REQ-021 Counter n SHALL increment on each edge with vld_out_n=1 and read_enb_n=0 (stall), and clear to 0 on any edge with vld_out_n=0 or read_enb_n=1.
REQ-022 On a stall edge with counter n =29 (30th consecutive stall edge), counter n SHALL clear to 0 and soft_reset_n SHALL be 1 for exactly the next cycle.
REQ-023 soft_reset_n SHALL be 0 in every cycle not covered by REQ-022.
REQ-024 Continued stall SHALL produce a further pulse every 30 edges; a read_enb_n pulse at any count restarts the 30-edge window.
REQ-025 Ports SHALL time out independently; simultaneous timeouts SHALL assert multiple soft_reset bits in the same cycle.
REQ-026 Counter n SHALL never exceed 29 and SHALL not wrap.
REQ-027 A soft_reset pulse SHALL not change the address register or write_enb decode.

Reset
REQ-028 resetn=0 SHALL immediately, asynchronously set addr=2'b11, all counters=0, soft_reset_0..2=0, hence write_enb=3'b000 and fifo_full=0.
REQ-029 vld_out_n SHALL follow empty_n during reset.
REQ-030 Reset mid-timeout SHALL discard the partial count; counting restarts from 0 after release.

Verification
REQ-031 Reset, then detect_add=1, data_in=2'b01 for one edge, then write_enb_reg=1 -> write_enb=3'b010; full_1=1 -> fifo_full=1, full_0=1 alone -> fifo_full=0.
REQ-032 detect_add=1, data_in=2'b11, write_enb_reg=1 -> write_enb=3'b000, fifo_full=0.
REQ-033 empty_2=0, read_enb_2=0 for 30 edges -> soft_reset_2=1 for exactly one cycle after edge 30, 0 after; counter back to 0.
REQ-034 empty_0=0, read_enb_0 pulsed at edge 20, then held 0 -> no pulse at edge 30; pulse after edge 50.
REQ-035 empty_0=empty_1=0, both unread 30 edges -> soft_reset_0 and soft_reset_1 pulse in the same cycle.
REQ-036 resetn pulsed low at stall edge 15 of port 1 -> counter clears; pulse only after 30 further stall edges post-release.
